// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory, and presents instructions or bubbles to IF/ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] hold_instr, hold_instr_next;
    logic [31:0] hold_pc, hold_pc_next;
    logic [31:0] stale_addr, stale_addr_next;
    logic [31:0] target;
    logic        ack;

    assign target = redirect_pc & 32'hFFFF_FFFC;

    // State and buffer registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
            hold_pc    <= 32'h0000_0000;
            stale_addr <= 32'h0000_0000;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            hold_instr <= hold_instr_next;
            hold_pc    <= hold_pc_next;
            stale_addr <= stale_addr_next;
        end
    end

    // Next-state logic and presented outputs; a response is used the cycle it arrives.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        hold_instr_next = hold_instr;
        hold_pc_next    = hold_pc;
        stale_addr_next = stale_addr;
        imem_req        = 1'b0;
        imem_addr       = pc;
        ack             = 1'b0;
        PC_out          = 32'h0000_0000;
        instr_out       = NOP_INSTR;
        valid_out       = 1'b0;

        case (state)
            FETCH: begin
                imem_req = ~rst;
                ack      = imem_ack & ~rst;
                if (redirect) begin
                    pc_next = target;
                    if (ack) begin
                        state_next = FETCH;
                    end else begin
                        // The in-flight response must still be consumed and dropped.
                        stale_addr_next = pc;
                        state_next      = DISCARD;
                    end
                end else if (ack) begin
                    PC_out    = pc;
                    instr_out = imem_rdata;
                    valid_out = 1'b1;
                    if (stall_in) begin
                        hold_instr_next = imem_rdata;
                        hold_pc_next    = pc;
                        state_next      = HOLD;
                    end else begin
                        pc_next    = pc + 32'd4;
                        state_next = FETCH;
                    end
                end else begin
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else begin
                    PC_out    = hold_pc;
                    instr_out = hold_instr;
                    valid_out = 1'b1;
                    if (stall_in) begin
                        state_next = HOLD;
                    end else begin
                        pc_next    = hold_pc + 32'd4;
                        state_next = FETCH;
                    end
                end
            end
            DISCARD: begin
                imem_req  = ~rst;
                imem_addr = stale_addr;
                ack       = imem_ack & ~rst;
                if (redirect) begin
                    pc_next    = target;
                    state_next = DISCARD;
                end else if (ack) begin
                    state_next = FETCH;
                end else begin
                    state_next = DISCARD;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues single-outstanding fetch requests to a variable-latency instruction memory. It presents either a fetched instruction or a NOP bubble (PC 0, instruction 32'h00000013) to IF/ID, and it honours pipeline stall and branch/jump redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  1  IF/ID hold request from the hazard unit.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  fetch request; level, held until ack.
- imem_addr  out  32  fetch address; stable while imem_req is high and no ack has arrived.
- imem_ack  in  1  response valid; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- PC_out  out  32  PC of the presented instruction (to IF/ID PC_in).
- instr_out  out  32  presented instruction (to IF/ID instr_in).
- valid_out  out  1  1 = real instruction, 0 = bubble.

## Operation
- Registers:
  - pc: next fetch address.
  - state: FETCH, HOLD or DISCARD.
  - hold_instr / hold_pc: one-entry buffer.
  - stale_addr: address of a request that must be dropped.
- Bubble output whenever valid_out=0: PC_out=0, instr_out=NOP_INSTR.
- Priority: redirect > imem_ack > stall_in.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On ack with no redirect: outputs are PC_out=pc, instr_out=imem_rdata, valid_out=1 (combinational, same cycle).
    - If stall_in=0: pc<=pc+4, stay in FETCH.
    - If stall_in=1: hold_instr<=imem_rdata, hold_pc<=pc, go to HOLD.
  - No ack: bubble, stay in FETCH.
- HOLD:
  - imem_req=0; outputs come from the buffer with valid_out=1.
  - When stall_in=0: pc<=hold_pc+4, go to FETCH.
- DISCARD:
  - imem_req=1, imem_addr=stale_addr; outputs are a bubble.
  - On ack: data dropped, go to FETCH using the already-updated pc.
- Redirect (any state): pc<={redirect_pc[31:2],2'b00}; outputs are a bubble that cycle; any ack data that cycle is dropped.
  - FETCH with no ack this cycle: stale_addr<=pc, go to DISCARD.
  - FETCH with ack this cycle: go to FETCH.
  - HOLD: buffer dropped, go to FETCH.
  - DISCARD: stay in DISCARD; stale_addr is unchanged, pc takes the newest target.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC+4 = 0.

## Timing
- Reset values (asynchronous, while rst=1):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0 (gated by rst), imem_addr=RESET_PC.
  - valid_out=0, PC_out=0, instr_out=NOP_INSTR.
  - hold_* = 0 / NOP_INSTR, stale_addr=0.
- First imem_req=1 occurs in the first cycle with rst=0.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, consecutive PCs.
- Fetch latency: response-to-output is 0 cycles (combinational); request-to-output equals memory latency.
- Redirect asserted in cycle N:
  - Bubble in cycle N.
  - Request to the target from cycle N+1.
  - With zero-wait memory, the target instruction is valid in N+1.
  - If the old request is still outstanding, the target request starts the cycle after the stale ack.
- Stall asserted with an instruction presented:
  - The same PC/instr is held on the outputs every stalled cycle.
  - No new request is issued while stalled.
  - The next fetch (pc+4) starts the cycle after stall_in drops.
- Only one request is ever outstanding; imem_addr never changes while a request is unacknowledged.
- Reset mid-request: state returns to FETCH, and the outstanding memory transaction is treated as abandoned by the memory (which is reset by the same rst).

## Test plan
- Reset, then zero-wait memory returning addr^32'hA5A5_0000 -> outputs PC 0,4,8,C on consecutive cycles with matching instr, valid_out=1.
- Ack latency 3 cycles -> imem_addr held at 0 for 3 cycles, bubbles (PC 0, instr 0x13) until the ack, then PC 0 valid for one cycle; next request at 4.
- stall_in high for 4 cycles on the cycle PC 8 is presented -> PC 8 and its instr held all 4 cycles, imem_req=0; request for C the cycle after release.
- redirect to 0x100 while the request for 0x10 is outstanding (ack 2 cycles later) -> the 0x10 data is never presented as valid; next request is at 0x100, then instr at PC 0x100 valid.
- redirect to 0x203 on the same cycle as an ack and with stall_in=1 -> bubble that cycle, next request at 0x200.
- Redirect to 0xFFFF_FFFC with zero-wait memory -> PC 0xFFFF_FFFC then 0x0000_0000.
- rst pulsed while in HOLD -> outputs return to a bubble immediately; first request at RESET_PC after release.
